// File: rtl/crc_stream_ctrl.sv
// Byte-serial CRC sequencer: framed valid/ready/last byte stream in,
// CRC/length/residue result out, one byte per clock.
module crc_stream_ctrl #(
  parameter int                     CRC_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0]   POLY      = CRC_WIDTH'(32'h04C11DB7),
  parameter logic [CRC_WIDTH-1:0]   INIT      = CRC_WIDTH'(32'hFFFFFFFF),
  parameter logic [CRC_WIDTH-1:0]   XOROUT    = CRC_WIDTH'(32'hFFFFFFFF),
  parameter logic [CRC_WIDTH-1:0]   RESIDUE   = CRC_WIDTH'(32'hDEBB20E3),
  parameter int                     LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [CRC_WIDTH-1:0] res_crc,
  output logic [LEN_WIDTH-1:0] res_len,
  output logic                 res_ok,
  output logic                 res_valid,
  input  logic                 res_ready
);

  localparam int                   LUT_IWIDTH    = 8;
  localparam int                   LUT_OWIDTH    = CRC_WIDTH;
  localparam logic [LUT_OWIDTH-1:0] LUT_XN       = '0;
  localparam bit                   LUT_LSB_FIRST = 1'b1;

  function automatic logic [LUT_OWIDTH-1:0] f_reflect(
    input logic [LUT_OWIDTH-1:0] v
  );
    logic [LUT_OWIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < LUT_OWIDTH; i++) begin
      r[i] = v[LUT_OWIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [LUT_OWIDTH-1:0] POLY_REV = f_reflect(POLY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [CRC_WIDTH-1:0]   r_crc;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [CRC_WIDTH-1:0]   r_res_crc;
  logic [LEN_WIDTH-1:0]   r_res_len;
  logic                   r_res_ok;
  logic                   r_res_valid;

  logic [CRC_WIDTH-1:0]   w_crc_cur;
  logic [LUT_IWIDTH-1:0]  w_lut_addr;
  logic [LUT_OWIDTH-1:0]  w_lut_data;
  logic [LUT_OWIDTH-1:0]  w_lut_acc;
  logic [CRC_WIDTH-1:0]   w_crc_next;
  logic [LEN_WIDTH-1:0]   w_len_inc;
  logic [LEN_WIDTH-1:0]   w_len_next;

  logic                   w_rdy;
  logic                   w_load;
  logic                   w_clear;
  logic                   w_capture;
  logic                   w_release;

  // A new frame always starts from INIT, whatever r_crc holds.
  assign w_crc_cur  = (r_state == S_IDLE) ? INIT : r_crc;
  assign w_lut_addr = w_crc_cur[7:0] ^ in_data;
  assign w_crc_next = (w_crc_cur >> 8) ^ w_lut_data;

  always_comb begin : u_lut
    w_lut_acc = '0;
    if (LUT_LSB_FIRST) begin
      w_lut_acc[LUT_IWIDTH-1:0] = w_lut_addr;
      for (int i = 0; i < LUT_IWIDTH; i++) begin
        if (w_lut_acc[0]) begin
          w_lut_acc = (w_lut_acc >> 1) ^ POLY_REV;
        end else begin
          w_lut_acc = w_lut_acc >> 1;
        end
      end
    end else begin
      w_lut_acc[LUT_OWIDTH-1 -: LUT_IWIDTH] = w_lut_addr;
      for (int i = 0; i < LUT_IWIDTH; i++) begin
        if (w_lut_acc[LUT_OWIDTH-1]) begin
          w_lut_acc = (w_lut_acc << 1) ^ POLY;
        end else begin
          w_lut_acc = w_lut_acc << 1;
        end
      end
    end
    w_lut_data = w_lut_acc ^ LUT_XN;
  end

  assign w_len_inc = (r_len == '1) ? r_len
                                   : r_len + LEN_WIDTH'(1);
  assign w_len_next = (r_state == S_IDLE) ? LEN_WIDTH'(1)
                                          : w_len_inc;

  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      S_IDLE, S_RUN: begin
        w_rdy = !abort;
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else if (in_valid) begin
          w_load = 1'b1;
          if (in_last) begin
            w_state_nxt = S_DONE;
            w_capture   = 1'b1;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_crc       <= INIT;
      r_len       <= '0;
      r_res_crc   <= '0;
      r_res_len   <= '0;
      r_res_ok    <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_crc <= INIT;
        r_len <= '0;
      end else if (w_load) begin
        r_crc <= w_crc_next;
        r_len <= w_len_next;
      end
      if (w_capture) begin
        r_res_crc   <= w_crc_next ^ XOROUT;
        r_res_len   <= w_len_next;
        r_res_ok    <= (w_crc_next == RESIDUE);
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  // Held low through the reset cycle itself.
  assign in_ready  = w_rdy && !rst;
  assign res_crc   = r_res_crc;
  assign res_len   = r_res_len;
  assign res_ok    = r_res_ok;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_crc_stream_ctrl.sv
// Directed bench for crc_stream_ctrl with a result scoreboard;
// a second instance with LEN_WIDTH=4 covers length saturation.
module tb_crc_stream_ctrl;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [31:0] crc;
    logic [15:0] len;
    logic        ok;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        res_ready;

  logic        in_ready;
  logic [31:0] res_crc;
  logic [15:0] res_len;
  logic        res_ok;
  logic        res_valid;

  logic        b_in_ready;
  logic [31:0] b_res_crc;
  logic [3:0]  b_res_len;
  logic        b_res_ok;
  logic        b_res_valid;

  int   n_pass = 0;
  int   n_tot  = 0;
  exp_t sb[$];
  logic pv = 1'b0;

  always #5 clk = ~clk;

  crc_stream_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .res_crc   (res_crc),
    .res_len   (res_len),
    .res_ok    (res_ok),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  crc_stream_ctrl #(.LEN_WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .abort     (abort),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (b_in_ready),
    .res_crc   (b_res_crc),
    .res_len   (b_res_len),
    .res_ok    (b_res_ok),
    .res_valid (b_res_valid),
    .res_ready (res_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // Bit-serial reflected CRC-32; returns the register before XOROUT.
  function automatic logic [31:0] model_reg(input bq_t q);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return c;
  endfunction

  task automatic push_exp(input logic [31:0] crc,
                          input int len,
                          input logic ok);
    exp_t e;
    e.crc = crc;
    e.len = 16'(len);
    e.ok  = ok;
    sb.push_back(e);
  endtask

  task automatic push_model(input bq_t q);
    logic [31:0] r;
    r = model_reg(q);
    push_exp(r ^ 32'hFFFFFFFF, q.size(), r == 32'hDEBB20E3);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_wait", 32'(n < 100), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input bq_t q, input int gap);
    foreach (q[i]) begin
      send_byte(q[i], i == q.size() - 1);
      if (i < q.size() - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_crc"},   res_crc,        32'd0);
    chk({tag, "_len"},   32'(res_len),   32'd0);
    chk({tag, "_ok"},    32'(res_ok),    32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (res_valid && !pv) begin
      if (sb.size() == 0) begin
        n_tot++;
        $error("FAIL sb_empty: got crc %h want no result", res_crc);
      end else begin
        e = sb.pop_front();
        chk("res_crc",  res_crc,       e.crc);
        chk("res_len",  32'(res_len),  32'(e.len));
        chk("res_ok",   32'(res_ok),   32'(e.ok));
        chk("b_valid",  32'(b_res_valid), 32'd1);
        chk("b_crc",    b_res_crc,     e.crc);
        chk("b_len",    32'(b_res_len),
            (e.len > 16'd15) ? 32'd15 : 32'(e.len));
        chk("b_ok",     32'(b_res_ok), 32'(e.ok));
      end
    end
    pv <= res_valid;
  end

  initial begin
    #300000;
    $error("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t s9;
    bq_t q;
    s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
           8'h36, 8'h37, 8'h38, 8'h39};

    rst       = 1'b1;
    abort     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk_zero("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 32'(in_ready), 32'd1);

    // check string, back to back
    push_exp(32'hCBF43926, 9, 1'b0);
    send_frame(s9, 0);
    chk("lat1", 32'(res_valid), 32'd1);
    @(negedge clk);
    chk("idle2_valid", 32'(res_valid), 32'd0);
    chk("idle2_rdy", 32'(in_ready), 32'd1);

    // check string plus its own FCS
    q = s9;
    q.push_back(8'h26);
    q.push_back(8'h39);
    q.push_back(8'hF4);
    q.push_back(8'hCB);
    push_exp(32'h2144DF1C, 13, 1'b1);
    send_frame(q, 0);
    @(negedge clk);

    // single zero byte, then a gapped frame
    push_exp(32'hD202EF8D, 1, 1'b0);
    q = '{8'h00};
    send_frame(q, 0);
    push_exp(32'hCBF43926, 9, 1'b0);
    send_frame(s9, 1);
    @(negedge clk);

    // output backpressure
    res_ready = 1'b0;
    push_exp(32'hCBF43926, 9, 1'b0);
    send_frame(s9, 0);
    for (int i = 0; i < 5; i++) begin
      in_data  = 8'hAA;
      in_valid = 1'b1;
      in_last  = 1'b1;
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_crc", res_crc, 32'hCBF43926);
      chk("hold_len", 32'(res_len), 32'd9);
      chk("hold_rdy", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("drain_valid", 32'(res_valid), 32'd0);
    q = '{8'h41, 8'h42, 8'h43};
    push_model(q);
    send_frame(q, 0);
    @(negedge clk);

    // abort after four bytes, colliding with a valid byte
    for (int i = 0; i < 4; i++) send_byte(s9[i], 1'b0);
    abort    = 1'b1;
    in_data  = 8'h35;
    in_valid = 1'b1;
    in_last  = 1'b1;
    #1;
    chk("abort_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_noresult", 32'(res_valid), 32'd0);
    push_exp(32'hCBF43926, 9, 1'b0);
    send_frame(s9, 0);
    @(negedge clk);

    // reset mid-frame
    for (int i = 0; i < 5; i++) send_byte(s9[i], 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_rdy0", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero("rstmid");
    chk("rstmid_rdy1", 32'(in_ready), 32'd1);

    // reset while a result is pending
    res_ready = 1'b0;
    push_exp(32'hCBF43926, 9, 1'b0);
    send_frame(s9, 0);
    chk("pend_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rstdone");
    chk("rstdone_rdy0", 32'(in_ready), 32'd0);
    rst       = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("rstdone_rdy1", 32'(in_ready), 32'd1);
    push_exp(32'hCBF43926, 9, 1'b0);
    send_frame(s9, 0);
    @(negedge clk);

    // 20-byte frame saturates the 4-bit counter
    q = {};
    for (int i = 0; i < 20; i++) q.push_back(8'(i * 13 + 5));
    push_model(q);
    send_frame(q, 0);
    @(negedge clk);
    @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/crc_stream_ctrl.md
Name: crc_stream_ctrl

Overview:
- Byte-serial CRC sequencer. Accepts a framed byte stream through a valid/ready/last handshake and drives an internal byte-wide CRC lookup table, one byte per clock.
- At end of frame it presents the finished CRC, the frame length, and a residue-check flag, holding them under output backpressure.
- Sits between packet framers (Ethernet/UDP TX append, RX FCS check) and the CRC LUT datapath.

Parameters:
- CRC_WIDTH, 32, CRC register and result width; minimum 8.
- POLY, 32'h04C11DB7, normal-form polynomial excluding the msb; passed to the LUT.
- INIT, 32'hFFFFFFFF, CRC register seed at the first byte of each frame.
- XOROUT, 32'hFFFFFFFF, value XORed onto the final register to form res_crc.
- RESIDUE, 32'hDEBB20E3, register value (before XOROUT) that marks a good frame when the frame includes its own FCS.
- LEN_WIDTH, 16, width of the byte counter.

Ports:
- clk, input, 1, sole clock.
- rst, input, 1, synchronous, active-high reset.
- abort, input, 1, discards the current frame.
- in_data, input, 8, stream byte; processed lsb-first (reflected CRC).
- in_valid, input, 1, in_data is valid.
- in_last, input, 1, final byte of the frame; qualified by in_valid.
- in_ready, output, 1, byte accepted when in_valid && in_ready.
- res_crc, output, CRC_WIDTH, final CRC = register ^ XOROUT.
- res_len, output, LEN_WIDTH, bytes in the frame; saturating.
- res_ok, output, 1, register == RESIDUE at end of frame.
- res_valid, output, 1, result fields are valid.
- res_ready, input, 1, result consumed when res_valid && res_ready.

Behaviour:
- Datapath: one internal LUT instance, IWIDTH=8, OWIDTH=CRC_WIDTH, XN=0, LSB_FIRST=1.
  - LUT address = crc_cur[7:0] ^ in_data.
  - crc_next = (crc_cur >> 8) ^ lut_data.
  - crc_cur = INIT in IDLE, otherwise the crc register.
  - The LUT is combinational, so throughput is 1 byte/clk.
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On an accepted byte: crc <= crc_next (seeded from INIT), len <= 1. If in_last, go to DONE; otherwise go to RUN.
- RUN: in_ready=1. Each accepted byte: crc <= crc_next, len <= len+1, saturating at all-ones. If in_last, go to DONE. Idle cycles (in_valid=0) hold state.
- Transition into DONE: capture res_crc = crc_next ^ XOROUT, res_ok = (crc_next == RESIDUE), res_len = final count. Set res_valid=1 on the cycle after the last byte is accepted, so latency is 1 clk.
- DONE: in_ready=0. Result fields are held stable until res_valid && res_ready, then go to IDLE and res_valid=0 next cycle.
  - No same-cycle re-accept of a new byte.
  - Frame-to-frame gap is one cycle minimum.
- abort:
  - In IDLE or RUN: go to IDLE next cycle and clear crc and len. in_ready is forced to 0 while abort=1, so abort wins over a simultaneous valid byte and that byte is not consumed.
  - In DONE: ignored. The pending result must still be drained.
- in_last with in_valid=0 is ignored.
- Zero-length frames cannot occur; a frame always has at least one byte.
- Length counter: saturates at 2**LEN_WIDTH-1 and never wraps. CRC computation is unaffected by saturation.
- Reset (rst=1 at a clock edge, any state, including mid-frame or in DONE): state=IDLE, crc=INIT, len=0, res_valid=0, res_crc=0, res_len=0, res_ok=0.
  - in_ready=0 during the reset cycle and 1 from the following cycle.
  - Partial frames are discarded.
- All outputs are registered except in_ready, which is decoded from state and abort.

Test Plan:
- Frame of ASCII "123456789" (31..39), back-to-back, in_last on 0x39, res_ready=1 -> res_valid 1 clk after last byte; res_crc=32'hCBF43926, res_len=9, res_ok=0; IDLE two cycles after last byte.
- Same 9 bytes plus FCS bytes 26 39 F4 CB -> res_len=13, res_ok=1, res_crc=32'h2144DF1C (XOROUT of residue).
- Single byte 0x00 with in_last -> res_crc=32'hD202EF8D, res_len=1. Next frame "123456789" with in_valid toggling every other cycle -> 32'hCBF43926.
- Hold res_ready=0 for 5 clk after result -> res_* stable, in_ready=0, offered bytes not consumed. Assert res_ready -> res_valid drops next clk; next frame then computes correctly.
- abort after 4 bytes of "1234…", including a cycle with abort and in_valid both high -> no result and that byte dropped. Then the full "123456789" -> 32'hCBF43926, len 9.
- rst pulsed mid-frame and again while in DONE -> all outputs zero, in_ready=0 then 1. A fresh frame yields the correct CRC; LEN_WIDTH=4 with a 20-byte frame -> res_len=15 (saturated), CRC still correct.
